// File: rtl/noc_credit_port_bridge_if.sv
// ---------------------------------------------------------------------------
// noc_credit_port_bridge_if
//
// Purpose : bundles every per-channel handshake and data bus of the NoC
//           credit port bridge. Channel c of a flat data bus sits at bits
//           [c*DATA_WIDTH +: DATA_WIDTH].
//
// Modports:
//   master - the environment (clients plus router P ports). It drives the
//            client TX flits, the router output flits and yummies, and the
//            client RX ready.
//   slave  - the bridge itself.
//
// Signals:
//   tx_data/tx_valid/tx_ready          client -> bridge ready/valid stream
//   rtr_data_in/rtr_valid_in           bridge -> router dataIn_P/validIn_P
//   rtr_yummy_out                      router -> bridge credit return
//   rtr_data_out/rtr_valid_out         router -> bridge dataOut_P/validOut_P
//   rtr_yummy_in                       bridge -> router credit return
//   rx_data/rx_valid/rx_ready          bridge -> client ready/valid stream
//   err_rx_ovf/err_credit              sticky per-channel protocol errors
// ---------------------------------------------------------------------------
interface noc_credit_port_bridge_if #(
    parameter int DATA_WIDTH = 64,
    parameter int NUM_CH     = 25
);
    logic [NUM_CH*DATA_WIDTH-1:0] tx_data;
    logic [NUM_CH-1:0]            tx_valid;
    logic [NUM_CH-1:0]            tx_ready;
    logic [NUM_CH*DATA_WIDTH-1:0] rtr_data_in;
    logic [NUM_CH-1:0]            rtr_valid_in;
    logic [NUM_CH-1:0]            rtr_yummy_out;
    logic [NUM_CH*DATA_WIDTH-1:0] rtr_data_out;
    logic [NUM_CH-1:0]            rtr_valid_out;
    logic [NUM_CH-1:0]            rtr_yummy_in;
    logic [NUM_CH*DATA_WIDTH-1:0] rx_data;
    logic [NUM_CH-1:0]            rx_valid;
    logic [NUM_CH-1:0]            rx_ready;
    logic [NUM_CH-1:0]            err_rx_ovf;
    logic [NUM_CH-1:0]            err_credit;

    modport master (
        output tx_data, tx_valid, rtr_yummy_out, rtr_data_out, rtr_valid_out, rx_ready,
        input  tx_ready, rtr_data_in, rtr_valid_in, rtr_yummy_in, rx_data, rx_valid,
               err_rx_ovf, err_credit
    );

    modport slave (
        input  tx_data, tx_valid, rtr_yummy_out, rtr_data_out, rtr_valid_out, rx_ready,
        output tx_ready, rtr_data_in, rtr_valid_in, rtr_yummy_in, rx_data, rx_valid,
               err_rx_ovf, err_credit
    );
endinterface

// File: rtl/noc_credit_port_bridge.sv
// ---------------------------------------------------------------------------
// noc_credit_port_bridge
//
// Purpose : bridges NUM_CH client ready/valid streams to the local (P) ports
//           of the mesh routers, one fully independent channel per router.
//           TX: client flits are queued in a TX FIFO and forwarded to the
//               router under credit control (one credit per router buffer
//               slot, returned by rtr_yummy_out pulses).
//           RX: router flits are queued in an RX FIFO (show-ahead) and every
//               flit the client pops is acknowledged with one registered
//               rtr_yummy_in pulse.
//
// Ports   :
//   clk       rising-edge clock
//   reset_in  asynchronous active-low reset (shared with the routers)
//   port_if   noc_credit_port_bridge_if.slave, all channel buses
//
// Build option:
//   NOC_BRIDGE_ERR_CHECK_EN  when defined, err_rx_ovf / err_credit are built
//                            as sticky flags; otherwise they are tied to 0.
//                            Overflowing RX flits are dropped and excess
//                            yummies are ignored in both builds.
// ---------------------------------------------------------------------------
module noc_credit_port_bridge #(
    parameter int DATA_WIDTH = 64,
    parameter int NUM_CH     = 25,
    parameter int TX_DEPTH   = 4,
    parameter int RX_DEPTH   = 4,
    parameter int CREDITS    = 4
) (
    input  logic                       clk,
    input  logic                       reset_in,
    noc_credit_port_bridge_if.slave    port_if
);

    localparam int TX_AW = $clog2(TX_DEPTH);
    localparam int TX_PW = TX_AW + 1;
    localparam int RX_AW = $clog2(RX_DEPTH);
    localparam int RX_PW = RX_AW + 1;
    localparam int CW    = $clog2(CREDITS + 1);

    localparam logic [CW-1:0]    CRED_MAX   = CW'(CREDITS);
    localparam logic [CW-1:0]    CRED_ONE   = CW'(1);
    localparam logic [CW-1:0]    CRED_ZERO  = CW'(0);
    localparam logic [TX_PW-1:0] TX_PTR_ONE = TX_PW'(1);
    localparam logic [RX_PW-1:0] RX_PTR_ONE = RX_PW'(1);

    typedef logic [DATA_WIDTH-1:0] flit_t;

    // Pointers carry one extra wrap bit: equal low bits with differing wrap
    // bits means the FIFO is full, fully equal pointers mean empty.
    function automatic logic tx_is_full(input logic [TX_PW-1:0] wr, input logic [TX_PW-1:0] rd);
        return (wr[TX_PW-1] != rd[TX_PW-1]) && (wr[TX_AW-1:0] == rd[TX_AW-1:0]);
    endfunction

    function automatic logic rx_is_full(input logic [RX_PW-1:0] wr, input logic [RX_PW-1:0] rd);
        return (wr[RX_PW-1] != rd[RX_PW-1]) && (wr[RX_AW-1:0] == rd[RX_AW-1:0]);
    endfunction

    // ---------------- TX path state ----------------
    flit_t                        tx_mem_q [NUM_CH][TX_DEPTH];
    logic [TX_PW-1:0]             tx_wr_q  [NUM_CH];
    logic [TX_PW-1:0]             tx_wr_d  [NUM_CH];
    logic [TX_PW-1:0]             tx_rd_q  [NUM_CH];
    logic [TX_PW-1:0]             tx_rd_d  [NUM_CH];
    logic [CW-1:0]                credit_q [NUM_CH];
    logic [CW-1:0]                credit_d [NUM_CH];
    logic [NUM_CH-1:0]            tx_ready_q;
    logic [NUM_CH-1:0]            tx_ready_d;
    logic [NUM_CH-1:0]            rtr_valid_in_q;
    logic [NUM_CH*DATA_WIDTH-1:0] rtr_data_in_q;
    logic [NUM_CH*DATA_WIDTH-1:0] rtr_data_in_d;
    logic [NUM_CH-1:0]            tx_push_s;
    logic [NUM_CH-1:0]            tx_send_s;
    logic [NUM_CH-1:0]            credit_full_s;
    logic [NUM_CH-1:0]            yummy_ok_s;

    // ---------------- RX path state ----------------
    flit_t                        rx_mem_q [NUM_CH][RX_DEPTH];
    logic [RX_PW-1:0]             rx_wr_q  [NUM_CH];
    logic [RX_PW-1:0]             rx_wr_d  [NUM_CH];
    logic [RX_PW-1:0]             rx_rd_q  [NUM_CH];
    logic [RX_PW-1:0]             rx_rd_d  [NUM_CH];
    logic [NUM_CH-1:0]            rx_valid_q;
    logic [NUM_CH-1:0]            rx_valid_d;
    logic [NUM_CH-1:0]            rx_full_q;
    logic [NUM_CH-1:0]            rx_full_d;
    logic [NUM_CH-1:0]            rtr_yummy_in_q;
    logic [NUM_CH-1:0]            rx_push_s;
    logic [NUM_CH-1:0]            rx_pop_s;
    logic [NUM_CH*DATA_WIDTH-1:0] rx_data_s;

    // TX next-state: push, send decision (with empty-FIFO bypass), credit update.
    always_comb begin
        tx_push_s     = {NUM_CH{1'b0}};
        tx_send_s     = {NUM_CH{1'b0}};
        credit_full_s = {NUM_CH{1'b0}};
        yummy_ok_s    = {NUM_CH{1'b0}};
        tx_ready_d    = tx_ready_q;
        rtr_data_in_d = rtr_data_in_q;
        for (int c = 0; c < NUM_CH; c++) begin
            tx_wr_d[c]  = tx_wr_q[c];
            tx_rd_d[c]  = tx_rd_q[c];
            credit_d[c] = credit_q[c];

            tx_push_s[c] = port_if.tx_valid[c] & tx_ready_q[c];
            // A flit pushed into an empty FIFO may leave in the same cycle so
            // that rtr_valid_in follows a push by exactly one cycle.
            tx_send_s[c] = ((tx_wr_q[c] != tx_rd_q[c]) | tx_push_s[c])
                           & (credit_q[c] != CRED_ZERO);
            // A yummy with every credit already home has nothing to return.
            credit_full_s[c] = (credit_q[c] == CRED_MAX);
            yummy_ok_s[c]    = port_if.rtr_yummy_out[c] & ~credit_full_s[c];

            if (tx_push_s[c]) begin
                tx_wr_d[c] = tx_wr_q[c] + TX_PTR_ONE;
            end else begin
                tx_wr_d[c] = tx_wr_q[c];
            end

            if (tx_send_s[c]) begin
                tx_rd_d[c] = tx_rd_q[c] + TX_PTR_ONE;
                if (tx_wr_q[c] != tx_rd_q[c]) begin
                    rtr_data_in_d[c*DATA_WIDTH +: DATA_WIDTH] = tx_mem_q[c][tx_rd_q[c][TX_AW-1:0]];
                end else begin
                    rtr_data_in_d[c*DATA_WIDTH +: DATA_WIDTH] = port_if.tx_data[c*DATA_WIDTH +: DATA_WIDTH];
                end
            end else begin
                tx_rd_d[c] = tx_rd_q[c];
            end

            if (tx_send_s[c] && !yummy_ok_s[c]) begin
                credit_d[c] = credit_q[c] - CRED_ONE;
            end else if (!tx_send_s[c] && yummy_ok_s[c]) begin
                credit_d[c] = credit_q[c] + CRED_ONE;
            end else begin
                credit_d[c] = credit_q[c];
            end

            tx_ready_d[c] = ~tx_is_full(tx_wr_d[c], tx_rd_d[c]);
        end
    end

    // RX next-state: accept router flits unless full without a pop, show-ahead head.
    always_comb begin
        rx_push_s  = {NUM_CH{1'b0}};
        rx_pop_s   = {NUM_CH{1'b0}};
        rx_valid_d = rx_valid_q;
        rx_full_d  = rx_full_q;
        rx_data_s  = {(NUM_CH*DATA_WIDTH){1'b0}};
        for (int c = 0; c < NUM_CH; c++) begin
            rx_wr_d[c] = rx_wr_q[c];
            rx_rd_d[c] = rx_rd_q[c];

            rx_pop_s[c]  = rx_valid_q[c] & port_if.rx_ready[c];
            // When full, a same-cycle pop frees the slot the push lands in.
            rx_push_s[c] = port_if.rtr_valid_out[c] & (~rx_full_q[c] | rx_pop_s[c]);

            if (rx_push_s[c]) begin
                rx_wr_d[c] = rx_wr_q[c] + RX_PTR_ONE;
            end else begin
                rx_wr_d[c] = rx_wr_q[c];
            end

            if (rx_pop_s[c]) begin
                rx_rd_d[c] = rx_rd_q[c] + RX_PTR_ONE;
            end else begin
                rx_rd_d[c] = rx_rd_q[c];
            end

            rx_valid_d[c] = (rx_wr_d[c] != rx_rd_d[c]);
            rx_full_d[c]  = rx_is_full(rx_wr_d[c], rx_rd_d[c]);
            rx_data_s[c*DATA_WIDTH +: DATA_WIDTH] = rx_mem_q[c][rx_rd_q[c][RX_AW-1:0]];
        end
    end

    // Control registers: pointers, credits, flags and the router-facing outputs.
    always_ff @(posedge clk or negedge reset_in) begin
        if (!reset_in) begin
            for (int c = 0; c < NUM_CH; c++) begin
                tx_wr_q[c]  <= {TX_PW{1'b0}};
                tx_rd_q[c]  <= {TX_PW{1'b0}};
                credit_q[c] <= CRED_MAX;
                rx_wr_q[c]  <= {RX_PW{1'b0}};
                rx_rd_q[c]  <= {RX_PW{1'b0}};
            end
            tx_ready_q     <= {NUM_CH{1'b1}};
            rtr_valid_in_q <= {NUM_CH{1'b0}};
            rtr_data_in_q  <= {(NUM_CH*DATA_WIDTH){1'b0}};
            rx_valid_q     <= {NUM_CH{1'b0}};
            rx_full_q      <= {NUM_CH{1'b0}};
            rtr_yummy_in_q <= {NUM_CH{1'b0}};
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                tx_wr_q[c]  <= tx_wr_d[c];
                tx_rd_q[c]  <= tx_rd_d[c];
                credit_q[c] <= credit_d[c];
                rx_wr_q[c]  <= rx_wr_d[c];
                rx_rd_q[c]  <= rx_rd_d[c];
            end
            tx_ready_q     <= tx_ready_d;
            rtr_valid_in_q <= tx_send_s;
            rtr_data_in_q  <= rtr_data_in_d;
            rx_valid_q     <= rx_valid_d;
            rx_full_q      <= rx_full_d;
            rtr_yummy_in_q <= rx_pop_s;
        end
    end

    // FIFO storage writes; contents need no reset because the pointers gate them.
    always_ff @(posedge clk) begin
        for (int c = 0; c < NUM_CH; c++) begin
            if (tx_push_s[c]) begin
                tx_mem_q[c][tx_wr_q[c][TX_AW-1:0]] <= port_if.tx_data[c*DATA_WIDTH +: DATA_WIDTH];
            end
            if (rx_push_s[c]) begin
                rx_mem_q[c][rx_wr_q[c][RX_AW-1:0]] <= port_if.rtr_data_out[c*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

`ifdef NOC_BRIDGE_ERR_CHECK_EN
    logic [NUM_CH-1:0] err_rx_ovf_q;
    logic [NUM_CH-1:0] err_rx_ovf_d;
    logic [NUM_CH-1:0] err_credit_q;
    logic [NUM_CH-1:0] err_credit_d;

    // Sticky error next-state: dropped RX flit or yummy with no credit outstanding.
    always_comb begin
        err_rx_ovf_d = err_rx_ovf_q
                       | (port_if.rtr_valid_out & rx_full_q & ~rx_pop_s);
        err_credit_d = err_credit_q
                       | (port_if.rtr_yummy_out & credit_full_s);
    end

    // Sticky error registers, cleared only by reset.
    always_ff @(posedge clk or negedge reset_in) begin
        if (!reset_in) begin
            err_rx_ovf_q <= {NUM_CH{1'b0}};
            err_credit_q <= {NUM_CH{1'b0}};
        end else begin
            err_rx_ovf_q <= err_rx_ovf_d;
            err_credit_q <= err_credit_d;
        end
    end

    assign port_if.err_rx_ovf = err_rx_ovf_q;
    assign port_if.err_credit = err_credit_q;
`else
    assign port_if.err_rx_ovf = {NUM_CH{1'b0}};
    assign port_if.err_credit = {NUM_CH{1'b0}};
`endif

    assign port_if.tx_ready     = tx_ready_q;
    assign port_if.rtr_valid_in = rtr_valid_in_q;
    assign port_if.rtr_data_in  = rtr_data_in_q;
    assign port_if.rtr_yummy_in = rtr_yummy_in_q;
    assign port_if.rx_valid     = rx_valid_q;
    assign port_if.rx_data      = rx_data_s;

endmodule
